yacc_line_compressor: RTL and testbench



---
 rtl/yacc_pkg.sv | 21 ++
 rtl/yacc_line_compressor_if.sv | 32 +++
 rtl/yacc_zero_tracker.sv | 57 +++++
 rtl/yacc_line_compressor.sv | 135 +++++++++++++
 tb/tb_yacc_line_compressor.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/yacc_pkg.sv
// Shared types and constants for the YACC fill-path line compressor.
package yacc_pkg;

  localparam int BEAT_W   = 64;
  localparam int LINE_W   = 512;
  localparam int OFFSET_W = 6;
  localparam int BEATS    = LINE_W / BEAT_W;

  typedef enum logic [1:0] {
    CF_NONE    = 2'b00,
    CF_HALF    = 2'b01,
    CF_QUARTER = 2'b10
  } cf_e;

  // FSM encoding kept as plain constants so older tools can consume the package.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FILL = 2'd1;
  localparam state_t ST_EMIT = 2'd2;

endpackage

// File: rtl/yacc_line_compressor_if.sv
// Request, memory-beat and output-line channels of the line compressor.
// All three channels are valid/ready: a transfer happens on a rising clock edge where both are high.
interface yacc_line_compressor_if #(
  parameter int ADDR_W = 32
);
  import yacc_pkg::*;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;

  logic              mem_valid;
  logic [BEAT_W-1:0] mem_data;
  logic              mem_ready;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [LINE_W-1:0] out_data;
  cf_e               out_cf;

  modport master (
    output req_valid, req_addr, mem_valid, mem_data, out_ready,
    input  req_ready, mem_ready, out_valid, out_addr, out_data, out_cf
  );

  modport slave (
    input  req_valid, req_addr, mem_valid, mem_data, out_ready,
    output req_ready, mem_ready, out_valid, out_addr, out_data, out_cf
  );

endinterface

// File: rtl/yacc_zero_tracker.sv
// Per-beat nonzero flags for the middle (beats 2-3) and high (beats 4-7) line regions.
// nz_mid exists only when YACC_CF4_EN is defined.
module yacc_zero_tracker
  import yacc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic [2:0]        beat_cnt_i,
`ifdef YACC_CF4_EN
  output logic              nz_mid_o,
`endif
  output logic              nz_hi_o
);

  logic beat_nz;
  logic nz_hi_q, nz_hi_d;

  assign beat_nz = |beat_i;

  always_comb begin
    nz_hi_d = nz_hi_q;
    if (clear_i)
      nz_hi_d = 1'b0;
    else if (accept_i && (beat_cnt_i >= 3'd4) && beat_nz)
      nz_hi_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) nz_hi_q <= 1'b0;
    else       nz_hi_q <= nz_hi_d;
  end

  assign nz_hi_o = nz_hi_q;

`ifdef YACC_CF4_EN
  logic nz_mid_q, nz_mid_d;

  always_comb begin
    nz_mid_d = nz_mid_q;
    if (clear_i)
      nz_mid_d = 1'b0;
    else if (accept_i && ((beat_cnt_i == 3'd2) || (beat_cnt_i == 3'd3)) && beat_nz)
      nz_mid_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) nz_mid_q <= 1'b0;
    else       nz_mid_q <= nz_mid_d;
  end

  assign nz_mid_o = nz_mid_q;
`endif

endmodule

// File: rtl/yacc_line_compressor.sv
// Collects a 512-bit miss line as eight beats, classifies and packs it for the YACC cache.
// YACC_CF4_EN enables the /4 class; without it such lines are emitted as /2.
module yacc_line_compressor
  import yacc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  yacc_line_compressor_if.slave   bus,
  output state_t                  dbg_state_o,
  output logic [2:0]              dbg_beat_cnt_o
);

  state_t                   state_q, state_d;
  logic [2:0]               beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]        out_addr_q, out_addr_d;
  logic [LINE_W-1:0]        out_data_q, out_data_d;
  cf_e                      out_cf_q, out_cf_d;
  logic [LINE_W-BEAT_W-1:0] line_q;

  logic req_fire, beat_fire, last_beat;
  logic nz_hi;
`ifdef YACC_CF4_EN
  logic nz_mid;
`endif

  assign req_fire  = (state_q == ST_IDLE) && bus.req_valid;
  assign beat_fire = (state_q == ST_FILL) && bus.mem_valid;
  assign last_beat = beat_fire && (beat_cnt_q == 3'd7);

  yacc_zero_tracker u_zero_tracker (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (req_fire),
    .accept_i   (beat_fire),
    .beat_i     (bus.mem_data),
    .beat_cnt_i (beat_cnt_q),
`ifdef YACC_CF4_EN
    .nz_mid_o   (nz_mid),
`endif
    .nz_hi_o    (nz_hi)
  );

  // Beat 7 is never buffered: it is merged straight from the bus on its accept cycle.
  logic [LINE_W-1:0] line_full;
  cf_e               cf_cls;
  logic [LINE_W-1:0] line_packed;

  always_comb begin
    line_full = {bus.mem_data, line_q};
    if (nz_hi || (|bus.mem_data))
      cf_cls = CF_NONE;
`ifdef YACC_CF4_EN
    else if (nz_mid)
      cf_cls = CF_HALF;
    else
      cf_cls = CF_QUARTER;
`else
    else
      cf_cls = CF_HALF;
`endif
    case (cf_cls)
      CF_NONE: line_packed = line_full;
      CF_HALF: line_packed = {{(LINE_W/2){1'b0}}, line_full[LINE_W/2-1:0]};
      default: line_packed = {{(LINE_W*3/4){1'b0}}, line_full[LINE_W/4-1:0]};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_cf_d   = out_cf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d    = ST_FILL;
          beat_cnt_d = 3'd0;
          out_addr_d = bus.req_addr & ~ADDR_W'((1 << OFFSET_W) - 1);
        end
      end
      ST_FILL: begin
        if (bus.mem_valid) begin
          beat_cnt_d = beat_cnt_q + 3'd1;
          if (last_beat) begin
            state_d    = ST_EMIT;
            out_data_d = line_packed;
            out_cf_d   = cf_cls;
          end
        end
      end
      ST_EMIT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 3'd0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_cf_q   <= CF_NONE;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_cf_q   <= out_cf_d;
    end
  end

  // Line buffer needs no reset: every slot is rewritten before it is read.
  always_ff @(posedge clock) begin
    for (int i = 0; i < BEATS - 1; i++) begin
      if (beat_fire && (beat_cnt_q == 3'(i)))
        line_q[i*BEAT_W +: BEAT_W] <= bus.mem_data;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.mem_ready = (state_q == ST_FILL);
  assign bus.out_valid = (state_q == ST_EMIT);
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_cf    = out_cf_q;

  assign dbg_state_o    = state_q;
  assign dbg_beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_yacc_line_compressor.sv
// Bench for yacc_line_compressor: directed cases with literal expectations plus random lines
// checked every cycle against a region-based model of classification and packing.
`timescale 1ns/1ps
module tb_yacc_line_compressor;
  import yacc_pkg::*;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  yacc_line_compressor_if #(.ADDR_W(32)) bus ();
  state_t     dbg_state;
  logic [2:0] dbg_beat_cnt;

  yacc_line_compressor #(.ADDR_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus.slave),
    .dbg_state_o    (dbg_state),
    .dbg_beat_cnt_o (dbg_beat_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit stall  = 1'b1;
  bit chk_en = 1'b0;

  logic [31:0]       exp_addr_q[$];
  logic [LINE_W-1:0] exp_data_q[$];
  logic [1:0]        exp_cf_q[$];

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // model: class from which line regions hold nonzero data
  function automatic logic [1:0] model_cf(input logic [LINE_W-1:0] line);
    if (line[511:256] != '0) return 2'b00;
    if (line[255:128] != '0) return 2'b01;
`ifdef YACC_CF4_EN
    return 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  function automatic logic [LINE_W-1:0] model_pack(input logic [LINE_W-1:0] line, input logic [1:0] cf);
    logic [LINE_W-1:0] r;
    r = line;
    if (cf == 2'b01)      r[511:256] = '0;
    else if (cf == 2'b10) r[511:128] = '0;
    return r;
  endfunction

  // scoreboard compare + out_ready driver
  always @(negedge clock) begin
    if (!reset && chk_en) begin
      check("onehot", LINE_W'($countones({bus.req_ready, bus.mem_ready, bus.out_valid})), LINE_W'(1));
      if (bus.out_valid) begin
        if (exp_cf_q.size() == 0) begin
          check("unexpected_out", LINE_W'(1), LINE_W'(0));
        end else begin
          check("out_addr", LINE_W'(bus.out_addr), LINE_W'(exp_addr_q[0]));
          check("out_data", bus.out_data, exp_data_q[0]);
          check("out_cf", LINE_W'(bus.out_cf), LINE_W'(exp_cf_q[0]));
        end
      end
      bus.out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (bus.out_valid && bus.out_ready && exp_cf_q.size() != 0) begin
        void'(exp_addr_q.pop_front());
        void'(exp_data_q.pop_front());
        void'(exp_cf_q.pop_front());
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic do_line(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                         input int gap_max, output int lat);
    int guard;
    int acc_cyc;
    int g;
    logic [1:0] cf;
    cf = model_cf(line);
    exp_addr_q.push_back({addr[31:6], 6'b0});
    exp_data_q.push_back(model_pack(line, cf));
    exp_cf_q.push_back(cf);
    lat = -1;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    guard = 0;
    while (!bus.req_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) begin
      check("req_timeout", LINE_W'(1), LINE_W'(0));
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clock);
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    for (int i = 0; i < BEATS; i++) begin
      g = (gap_max < 0) ? ((i == 0) ? 0 : 1) : $urandom_range(0, gap_max);
      repeat (g) begin
        bus.mem_valid = 1'b0;
        bus.mem_data  = {$urandom, $urandom};
        @(negedge clock);
      end
      bus.mem_valid = 1'b1;
      bus.mem_data  = line[i*BEAT_W +: BEAT_W];
      guard = 0;
      while (!bus.mem_ready && guard < 200) begin
        @(negedge clock);
        guard++;
      end
      if (guard >= 200) begin
        check("beat_timeout", LINE_W'(1), LINE_W'(0));
        bus.mem_valid = 1'b0;
        return;
      end
      @(negedge clock);
    end
    lat = cyc - acc_cyc;
    bus.mem_valid = 1'($urandom_range(0, 1));
    bus.mem_data  = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_cf_q.size() != 0 || !bus.req_ready) && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 500) check("drain_timeout", LINE_W'(1), LINE_W'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, LINE_W'(bus.req_ready), LINE_W'(1));
    check({tag, "_mem_ready"}, LINE_W'(bus.mem_ready), LINE_W'(0));
    check({tag, "_out_valid"}, LINE_W'(bus.out_valid), LINE_W'(0));
    check({tag, "_out_addr"}, LINE_W'(bus.out_addr), LINE_W'(0));
    check({tag, "_out_data"}, bus.out_data, LINE_W'(0));
    check({tag, "_out_cf"}, LINE_W'(bus.out_cf), LINE_W'(0));
    check({tag, "_state"}, LINE_W'(dbg_state), LINE_W'(ST_IDLE));
    check({tag, "_beat_cnt"}, LINE_W'(dbg_beat_cnt), LINE_W'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] lit;
    logic [1:0]        cf_q_lit;
    int lat;
    int cat;

`ifdef YACC_CF4_EN
    cf_q_lit = 2'b10;
`else
    cf_q_lit = 2'b01;
`endif
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clock);

    // full line, no stalls
    stall = 1'b1;
    for (int i = 0; i < BEATS; i++) line[i*BEAT_W +: BEAT_W] = 64'h1111_1111_1111_1111 * 64'(i + 1);
    do_line(32'h0000_1234, line, 0, lat);
    check("t1_latency", LINE_W'(lat), LINE_W'(8));
    check("t1_valid", LINE_W'(bus.out_valid), LINE_W'(1));
    check("t1_addr", LINE_W'(bus.out_addr), LINE_W'(32'h0000_1200));
    check("t1_cf", LINE_W'(bus.out_cf), LINE_W'(2'b00));
    check("t1_data", bus.out_data, line);

    // hold in EMIT with req/mem activity
    repeat (5) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = $urandom;
      bus.mem_valid = 1'b1;
      bus.mem_data  = {$urandom, $urandom};
      @(negedge clock);
      check("stall_req_ready", LINE_W'(bus.req_ready), LINE_W'(0));
      check("stall_mem_ready", LINE_W'(bus.mem_ready), LINE_W'(0));
      check("stall_out_valid", LINE_W'(bus.out_valid), LINE_W'(1));
      check("stall_beat_cnt", LINE_W'(dbg_beat_cnt), LINE_W'(0));
      check("stall_data", bus.out_data, line);
    end
    bus.req_valid = 1'b0;
    bus.mem_valid = 1'b0;
    stall = 1'b0;
    wait_idle();

    // beats 0-3 nonzero -> half
    stall = 1'b1;
    line = '0;
    for (int i = 0; i < 4; i++) line[i*BEAT_W +: BEAT_W] = {$urandom | 32'h1, $urandom};
    do_line(32'hABCD_EF7F, line, 0, lat);
    check("t2_cf", LINE_W'(bus.out_cf), LINE_W'(2'b01));
    check("t2_addr", LINE_W'(bus.out_addr), LINE_W'(32'hABCD_EF40));
    lit = '0;
    lit[255:0] = line[255:0];
    check("t2_data", bus.out_data, lit);
    stall = 1'b0;
    wait_idle();

    // only beats 0-1 nonzero -> quarter class
    stall = 1'b1;
    line = '0;
    line[63:0]   = 64'hDEAD_BEEF;
    line[127:64] = 64'h1;
    do_line(32'h0000_0040, line, 0, lat);
    check("t3_cf", LINE_W'(bus.out_cf), LINE_W'(cf_q_lit));
    lit = '0;
    lit[127:0] = {64'h1, 64'hDEAD_BEEF};
    check("t3_data", bus.out_data, lit);
    stall = 1'b0;
    wait_idle();

    // all-zero line, mem_valid toggled every cycle
    stall = 1'b1;
    line = '0;
    do_line(32'h8000_003F, line, -1, lat);
    check("t4_latency", LINE_W'(lat), LINE_W'(15));
    check("t4_cf", LINE_W'(bus.out_cf), LINE_W'(cf_q_lit));
    check("t4_data", bus.out_data, LINE_W'(0));
    stall = 1'b0;
    wait_idle();

    // reset after beat 4, then a fresh line must show no residue
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1357_9BDF;
    @(negedge clock);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_data  = {$urandom | 32'h1, $urandom};
      @(negedge clock);
    end
    check("abort_beat_cnt", LINE_W'(dbg_beat_cnt), LINE_W'(5));
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    @(negedge clock);
    check_reset_vals("abort");
    reset = 1'b0;
    @(negedge clock);
    stall = 1'b1;
    line = '0;
    line[63:0] = 64'h0123_4567_89AB_CDEF;
    do_line(32'h0000_2000, line, 1, lat);
    check("t5_cf", LINE_W'(bus.out_cf), LINE_W'(cf_q_lit));
    check("t5_data", bus.out_data, line);
    stall = 1'b0;
    wait_idle();

    // random back-to-back lines
    repeat (40) begin
      cat = $urandom_range(0, 3);
      for (int i = 0; i < BEATS; i++) begin
        line[i*BEAT_W +: BEAT_W] = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) line[i*BEAT_W +: BEAT_W] = '0;
      end
      case (cat)
        1: line[511:256] = '0;
        2: line[511:128] = '0;
        3: line = '0;
        default: ;
      endcase
      do_line($urandom, line, $urandom_range(0, 2), lat);
    end
    bus.mem_valid = 1'b0;
    wait_idle();
    check("final_queue_empty", LINE_W'(exp_cf_q.size()), LINE_W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
